// File: rtl/maze_pkg.sv
// Shared constants and types for the maze wall engine.
package maze_pkg;

  localparam int unsigned COORD_W_DEF = 10;
  localparam int unsigned SPEED_W_DEF = 4;

  // Motion modes; code 3 is treated as static.
  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_HORIZ  = 2'd1;
  localparam logic [1:0] MODE_VERT   = 2'd2;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  typedef enum logic {
    StIdle,
    StSweep
  } sweep_state_t;

endpackage

// File: rtl/wall_bounce_step.sv
// One bounce step on a single axis: advance by speed, clamp at the limits and turn around.
module wall_bounce_step import maze_pkg::*; #(
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned SPEED_W = SPEED_W_DEF
) (
  input  logic [COORD_W-1:0] p,
  input  logic               dir,
  input  logic [SPEED_W-1:0] speed,
  input  logic [COORD_W-1:0] lo,
  input  logic [COORD_W-1:0] hi,
  output logic [COORD_W-1:0] p_next,
  output logic               dir_next
);

  logic [COORD_W:0] p_ext;
  logic [COORD_W:0] spd_ext;
  logic [COORD_W:0] inc_sum;
  logic [COORD_W:0] dec_floor;

  // Sums carry one extra bit so a step past the top of the coordinate range clamps instead of wrapping.
  always_comb begin
    p_ext     = {1'b0, p};
    spd_ext   = (COORD_W + 1)'(speed);
    inc_sum   = p_ext + spd_ext;
    dec_floor = {1'b0, lo} + spd_ext;
    p_next    = p;
    dir_next  = dir;
    if (dir == DIR_INC) begin
      if (inc_sum >= {1'b0, hi}) begin
        p_next   = hi;
        dir_next = DIR_DEC;
      end else begin
        p_next = inc_sum[COORD_W-1:0];
      end
    end else begin
      if (p_ext < dec_floor) begin
        p_next   = lo;
        dir_next = DIR_INC;
      end else begin
        p_next = p - COORD_W'(speed);
      end
    end
  end

endmodule

// File: rtl/wall_engine.sv
// Table of moving wall rectangles: per-pixel hit test for every slot plus a one-slot-per-cycle
// motion sweep triggered by the frame tick.
module wall_engine import maze_pkg::*; #(
  parameter int unsigned N_WALLS = 18,
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned SPEED_W = SPEED_W_DEF,
  localparam int unsigned SEL_W = (N_WALLS > 1) ? $clog2(N_WALLS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] xCount,
  input  logic [COORD_W-1:0] yCount,
  input  logic               update,
  input  logic               run,
  input  logic               restart,
  input  logic               cfg_wr,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_dir,
  input  logic [SPEED_W-1:0] cfg_speed,
  input  logic [COORD_W-1:0] cfg_lo,
  input  logic [COORD_W-1:0] cfg_hi,
  output logic               cfg_ready,
  output logic               busy,
  output logic               overrun,
  output logic [N_WALLS-1:0] wall
);

  // Slot table; flat registers because the hit test reads every slot each cycle.
  logic [COORD_W-1:0] home_x_q [N_WALLS];
  logic [COORD_W-1:0] home_y_q [N_WALLS];
  logic [COORD_W-1:0] cur_x_q  [N_WALLS];
  logic [COORD_W-1:0] cur_y_q  [N_WALLS];
  logic [COORD_W-1:0] w_q      [N_WALLS];
  logic [COORD_W-1:0] h_q      [N_WALLS];
  logic [1:0]         mode_q   [N_WALLS];
  logic               dir_q    [N_WALLS];
  logic               init_dir_q [N_WALLS];
  logic [SPEED_W-1:0] speed_q  [N_WALLS];
  logic [COORD_W-1:0] lo_q     [N_WALLS];
  logic [COORD_W-1:0] hi_q     [N_WALLS];

  sweep_state_t       state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               update_q;
  logic               upd_edge;
  logic               last_slot;
  logic               cfg_accept;

  logic               sel_vert;
  logic               step_en;
  logic [COORD_W-1:0] step_p;
  logic [COORD_W-1:0] step_p_next;
  logic               step_dir_next;
  logic [N_WALLS-1:0] hit;

  assign upd_edge   = update & ~update_q;
  assign last_slot  = (idx_q == SEL_W'(N_WALLS - 1));
  assign busy       = (state_q == StSweep);
  assign cfg_ready  = ~busy;
  assign overrun    = overrun_q;
  assign cfg_accept = cfg_wr && cfg_ready && (32'(cfg_sel) < N_WALLS);

  // Only the axis selected by the slot's mode moves; mode 3 falls through as static.
  assign sel_vert = (mode_q[idx_q] == MODE_VERT);
  assign step_en  = run && ((mode_q[idx_q] == MODE_HORIZ) || sel_vert);
  assign step_p   = sel_vert ? cur_y_q[idx_q] : cur_x_q[idx_q];

  wall_bounce_step #(
    .COORD_W (COORD_W),
    .SPEED_W (SPEED_W)
  ) u_step (
    .p        (step_p),
    .dir      (dir_q[idx_q]),
    .speed    (speed_q[idx_q]),
    .lo       (lo_q[idx_q]),
    .hi       (hi_q[idx_q]),
    .p_next   (step_p_next),
    .dir_next (step_dir_next)
  );

  // Sweep sequencing: restart wins, then tick handling with one pending slot and a sticky overrun.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (restart) begin
      state_d   = StIdle;
      idx_d     = '0;
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (upd_edge || pending_q) begin
            state_d   = StSweep;
            idx_d     = '0;
            pending_d = 1'b0;
          end
        end
        StSweep: begin
          if (upd_edge) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
          end
          if (last_slot) begin
            idx_d = '0;
            if (pending_d) begin
              pending_d = 1'b0;
              state_d   = StSweep;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      update_q  <= update;
    end
  end

  // Slot table: restart rehomes everything; otherwise config load (idle only) or sweep step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_WALLS; i++) begin
        home_x_q[i]   <= '0;
        home_y_q[i]   <= '0;
        cur_x_q[i]    <= '0;
        cur_y_q[i]    <= '0;
        w_q[i]        <= '0;
        h_q[i]        <= '0;
        mode_q[i]     <= MODE_STATIC;
        dir_q[i]      <= DIR_INC;
        init_dir_q[i] <= DIR_INC;
        speed_q[i]    <= '0;
        lo_q[i]       <= '0;
        hi_q[i]       <= '0;
      end
    end else if (restart) begin
      for (int i = 0; i < N_WALLS; i++) begin
        cur_x_q[i] <= home_x_q[i];
        cur_y_q[i] <= home_y_q[i];
        dir_q[i]   <= init_dir_q[i];
      end
    end else begin
      if (cfg_accept) begin
        home_x_q[cfg_sel]   <= cfg_x;
        home_y_q[cfg_sel]   <= cfg_y;
        cur_x_q[cfg_sel]    <= cfg_x;
        cur_y_q[cfg_sel]    <= cfg_y;
        w_q[cfg_sel]        <= cfg_w;
        h_q[cfg_sel]        <= cfg_h;
        mode_q[cfg_sel]     <= cfg_mode;
        dir_q[cfg_sel]      <= cfg_dir;
        init_dir_q[cfg_sel] <= cfg_dir;
        speed_q[cfg_sel]    <= cfg_speed;
        lo_q[cfg_sel]       <= cfg_lo;
        hi_q[cfg_sel]       <= cfg_hi;
      end
      if (busy && step_en) begin
        if (sel_vert) cur_y_q[idx_q] <= step_p_next;
        else          cur_x_q[idx_q] <= step_p_next;
        dir_q[idx_q] <= step_dir_next;
      end
    end
  end

  // Strict interior test; right/bottom edges summed one bit wider so they never wrap.
  for (genvar g = 0; g < N_WALLS; g++) begin : g_hit
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    assign x_end  = {1'b0, cur_x_q[g]} + {1'b0, w_q[g]};
    assign y_end  = {1'b0, cur_y_q[g]} + {1'b0, h_q[g]};
    assign hit[g] = (xCount > cur_x_q[g]) && ({1'b0, xCount} < x_end) &&
                    (yCount > cur_y_q[g]) && ({1'b0, yCount} < y_end);
  end

  // Registered hit vector, one cycle behind the pixel counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wall <= '0;
    else      wall <= hit;
  end

endmodule

// File: tb/tb_wall_engine.sv
// Directed bench for wall_engine with the default 18 slots.
module tb_wall_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  xCount, yCount;
  logic        update, run, restart;
  logic        cfg_wr;
  logic [4:0]  cfg_sel;
  logic [9:0]  cfg_x, cfg_y, cfg_w, cfg_h, cfg_lo, cfg_hi;
  logic [1:0]  cfg_mode;
  logic        cfg_dir;
  logic [3:0]  cfg_speed;
  logic        cfg_ready, busy, overrun;
  logic [17:0] wall;

  int n_tests = 0;
  int n_fail  = 0;

  wall_engine dut (
    .clk       (clk),
    .rst       (rst),
    .xCount    (xCount),
    .yCount    (yCount),
    .update    (update),
    .run       (run),
    .restart   (restart),
    .cfg_wr    (cfg_wr),
    .cfg_sel   (cfg_sel),
    .cfg_x     (cfg_x),
    .cfg_y     (cfg_y),
    .cfg_w     (cfg_w),
    .cfg_h     (cfg_h),
    .cfg_mode  (cfg_mode),
    .cfg_dir   (cfg_dir),
    .cfg_speed (cfg_speed),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .cfg_ready (cfg_ready),
    .busy      (busy),
    .overrun   (overrun),
    .wall      (wall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_slot(input int sel, input int x, input int y, input int w, input int h,
                         input int mode, input int dir, input int spd, input int lo,
                         input int hi);
    cfg_sel = 5'(sel); cfg_x = 10'(x); cfg_y = 10'(y); cfg_w = 10'(w); cfg_h = 10'(h);
    cfg_mode = 2'(mode); cfg_dir = 1'(dir); cfg_speed = 4'(spd);
    cfg_lo = 10'(lo); cfg_hi = 10'(hi);
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic probe(input int x, input int y, output logic [17:0] v);
    xCount = 10'(x);
    yCount = 10'(y);
    step();
    v = wall;
  endtask

  // Returns {hit at point a, hit at point b} for one slot.
  task automatic pair_probe(input int slot, input int xa, input int ya, input int xb,
                            input int yb, output logic [1:0] got);
    logic [17:0] va, vb;
    probe(xa, ya, va);
    probe(xb, yb, vb);
    got = {va[slot], vb[slot]};
  endtask

  // Issue n ticks, each waited out to the end of its sweep (bounded).
  task automatic run_updates(input int n, output int timeouts, output int sweeps);
    bit seen;
    timeouts = 0;
    sweeps   = 0;
    for (int k = 0; k < n; k++) begin
      update = 1'b1;
      step();
      update = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if (!busy) break;
        seen = 1'b1;
        step();
      end
      if (busy) timeouts++;
      if (seen) sweeps++;
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (wall !== 18'd0) begin n_fail++; $display("FAIL reset_wall: got %h want 0", wall); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_tests++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
  endtask

  task automatic test_static_hit();
    logic [17:0] v;
    wr_slot(0, 40, 46, 540, 20, 0, 0, 0, 0, 0);
    probe(41, 47, v);
    n_tests++;
    if (v[0] !== 1'b1) begin n_fail++; $display("FAIL static_41_47: got %b want 1", v[0]); end
    probe(40, 47, v);
    n_tests++;
    if (v[0] !== 1'b0) begin n_fail++; $display("FAIL static_40_47: got %b want 0", v[0]); end
    probe(580, 47, v);
    n_tests++;
    if (v[0] !== 1'b0) begin n_fail++; $display("FAIL static_580_47: got %b want 0", v[0]); end
    probe(41, 66, v);
    n_tests++;
    if (v[0] !== 1'b0) begin n_fail++; $display("FAIL static_41_66: got %b want 0", v[0]); end
    probe(579, 65, v);
    n_tests++;
    if (v[0] !== 1'b1) begin n_fail++; $display("FAIL static_579_65: got %b want 1", v[0]); end
    // Slot index beyond the table must not land anywhere.
    wr_slot(20, 100, 300, 50, 50, 0, 0, 0, 0, 0);
    probe(101, 301, v);
    n_tests++;
    if (v !== 18'd0) begin n_fail++; $display("FAIL sel_oob: got %h want 0", v); end
  endtask

  task automatic test_horiz_bounce();
    logic [1:0] got;
    int to, sw;
    int tot_to = 0;
    wr_slot(1, 40, 200, 20, 20, 1, 0, 2, 0, 490);
    run_updates(224, to, sw); tot_to += to;
    pair_probe(1, 489, 201, 488, 201, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL horiz_224: got %b want 10 (x=488)", got); end
    run_updates(1, to, sw); tot_to += to;
    pair_probe(1, 491, 201, 490, 201, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL horiz_225: got %b want 10 (x=490)", got); end
    run_updates(1, to, sw); tot_to += to;
    pair_probe(1, 489, 201, 488, 201, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL horiz_226: got %b want 10 (x=488)", got); end
    run_updates(244, to, sw); tot_to += to;
    pair_probe(1, 1, 201, 0, 201, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL horiz_reach0: got %b want 10 (x=0)", got); end
    // At x=0 still heading down: this step clamps to lo and turns.
    run_updates(1, to, sw); tot_to += to;
    pair_probe(1, 1, 201, 0, 201, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL horiz_turn0: got %b want 10 (x=0)", got); end
    run_updates(1, to, sw); tot_to += to;
    pair_probe(1, 3, 201, 2, 201, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL horiz_after0: got %b want 10 (x=2)", got); end
    n_tests++;
    if (tot_to !== 0) begin n_fail++; $display("FAIL horiz_timeout: got %0d want 0", tot_to); end
  endtask

  task automatic test_clamp();
    logic [1:0] got;
    int to, sw;
    wr_slot(2, 600, 485, 20, 20, 2, 0, 4, 0, 490);
    run_updates(1, to, sw);
    pair_probe(2, 601, 490, 601, 489, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL clamp_489: got %b want 10", got); end
    run_updates(1, to, sw);
    pair_probe(2, 601, 491, 601, 490, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL clamp_490: got %b want 10", got); end
    run_updates(1, to, sw);
    pair_probe(2, 601, 487, 601, 486, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL clamp_turn_486: got %b want 10", got); end
    wr_slot(2, 600, 3, 20, 20, 2, 1, 4, 0, 490);
    run_updates(1, to, sw);
    pair_probe(2, 601, 1, 601, 0, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL clamp_lo_0: got %b want 10", got); end
    run_updates(1, to, sw);
    pair_probe(2, 601, 5, 601, 4, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL clamp_lo_4: got %b want 10", got); end
  endtask

  task automatic test_sweep_handshake();
    int cnt;
    logic [1:0] got;
    logic ov_mid;
    // Single sweep length and ready gating.
    update = 1'b1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_busy_pre: got %b want 0", busy); end
    step();
    update = 1'b0;
    n_tests++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_low: got %b want 0", cfg_ready); end
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (!busy) break;
      cnt++;
      step();
    end
    n_tests++;
    if (cnt !== 18) begin n_fail++; $display("FAIL hs_busy_len: got %0d want 18", cnt); end
    // Write attempted during a sweep must be dropped.
    update = 1'b1;
    step();
    update = 1'b0;
    wr_slot(0, 300, 300, 40, 40, 0, 0, 0, 0, 0);
    for (int c = 0; c < 60; c++) begin
      if (!busy) break;
      step();
    end
    pair_probe(0, 41, 47, 301, 301, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL hs_wr_busy: got %b want 10", got); end
    // Second edge queues one more sweep, third edge is lost.
    cnt = 0;
    ov_mid = 1'bx;
    update = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step();
      if (busy) cnt++;
      if (c == 5) ov_mid = overrun;
      update = (c == 2 || c == 6) ? 1'b1 : 1'b0;
    end
    n_tests++;
    if (cnt !== 36) begin n_fail++; $display("FAIL hs_b2b_len: got %0d want 36", cnt); end
    n_tests++;
    if (ov_mid !== 1'b0) begin n_fail++; $display("FAIL hs_ov_pending: got %b want 0", ov_mid); end
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL hs_overrun: got %b want 1", overrun); end
  endtask

  task automatic test_restart();
    logic [1:0] got;
    update = 1'b1;
    step();
    update = 1'b0;
    repeat (4) step();
    restart = 1'b1;
    update  = 1'b1;
    step();
    restart = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rs_busy: got %b want 0", busy); end
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL rs_overrun: got %b want 0", overrun); end
    step();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rs_edge_drop: got %b want 0", busy); end
    update = 1'b0;
    pair_probe(1, 41, 201, 40, 201, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL rs_home_x: got %b want 10 (x=40)", got); end
    pair_probe(2, 601, 4, 601, 3, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL rs_home_y: got %b want 10 (y=3)", got); end
  endtask

  task automatic test_run_low();
    logic [1:0] got;
    int to, sw;
    run = 1'b0;
    run_updates(10, to, sw);
    n_tests++;
    if (sw !== 10 || to !== 0) begin
      n_fail++; $display("FAIL run0_sweeps: got %0d/%0d want 10/0", sw, to);
    end
    pair_probe(1, 41, 201, 40, 201, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL run0_x: got %b want 10 (x=40)", got); end
    pair_probe(2, 601, 4, 601, 3, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL run0_y: got %b want 10 (y=3)", got); end
    // Motion resumes with the restored initial direction (slot 2 starts decreasing).
    run = 1'b1;
    run_updates(1, to, sw);
    pair_probe(1, 43, 201, 42, 201, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL run1_x: got %b want 10 (x=42)", got); end
    pair_probe(2, 601, 1, 601, 0, got);
    n_tests++;
    if (got !== 2'b10) begin n_fail++; $display("FAIL run1_y: got %b want 10 (y=0)", got); end
  endtask

  task automatic test_async_reset();
    xCount = 10'd41;
    yCount = 10'd47;
    update = 1'b1;
    step();
    update = 1'b0;
    step();
    update = 1'b1;
    step();
    update = 1'b0;
    step();
    update = 1'b1;
    step();
    update = 1'b0;
    n_tests++;
    if ({busy, overrun, wall[0]} !== 3'b111) begin
      n_fail++; $display("FAIL ar_pre: got %b want 111", {busy, overrun, wall[0]});
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (wall !== 18'd0) begin n_fail++; $display("FAIL ar_wall: got %h want 0", wall); end
    n_tests++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL ar_busy_ov: got %b%b want 00", busy, overrun);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0;
    xCount = '0; yCount = '0;
    update = 1'b0; run = 1'b1; restart = 1'b0;
    cfg_wr = 1'b0; cfg_sel = '0;
    cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0;
    cfg_mode = '0; cfg_dir = 1'b0; cfg_speed = '0; cfg_lo = '0; cfg_hi = '0;
    repeat (3) step();
    test_reset();
    rst = 1'b1;
    step();
    test_static_hit();
    test_horiz_bounce();
    test_clamp();
    test_sweep_handshake();
    test_restart();
    test_run_low();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
